pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline control unit for the in-order RISC-V core. It merges hazard and redirect requests from idu, exu and lsu and drives per-stage stall and flush controls plus the PC redirect. It sequences multi-cycle exu operations (mul/div) through a small state machine with a timeout watchdog. It sits beside the pipeline registers (pc, if/id, id/ex, ex/lsu) and feeds the PC generator.

## Interface
- MC_MAX_CYCLES, 40, cycles allowed in MC_WAIT before the watchdog fires (1..255)
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- id_load_use_i  input  1  idu: instruction in id needs the result of a load currently in ex
- ex_jump_i  input  1  exu: taken branch/jump in ex this cycle
- ex_jump_addr_i  input  32  exu: redirect target
- ex_mc_start_i  input  1  exu: multi-cycle op in ex; held until the stage advances
- ex_mc_done_i  input  1  mdu: result valid; level, held until the ex stage advances
- lsu_busy_i  input  1  lsu: memory access not complete
- stall_o  output  4  hold pipeline register; bit0 pc, bit1 if/id, bit2 id/ex, bit3 ex/lsu
- flush_o  output  3  load bubble; bit0 if/id, bit1 id/ex, bit2 ex/lsu
- pc_redirect_o  output  1  load ex_jump_addr_i into the PC
- pc_redirect_addr_o  output  32  redirect target (pass-through of ex_jump_addr_i)
- mc_busy_o  output  1  state is MC_WAIT
- mc_err_o  output  1  sticky watchdog error
- perf_stall_cnt_o  output  32  cycles with stall_o[0]=1
- perf_flush_cnt_o  output  32  accepted redirects

## Operation
- States: RUN (reset), MC_WAIT.
- RUN to MC_WAIT: ex_mc_start_i & !ex_mc_done_i & !lsu_busy_i & !ex_jump_i.
- MC_WAIT to RUN: ex_mc_done_i & !lsu_busy_i, or watchdog expiry.
- Watchdog: an 8-bit counter clears on entry to MC_WAIT and increments each MC_WAIT cycle. At MC_MAX_CYCLES: mc_err_o sets (sticky until rst), state returns to RUN, flush_o[2]=1 for that cycle (drops the hung op).
- Output priority, highest first:
  - rst: stall_o=4'b1111, flush_o=0, redirect=0.
  - lsu_busy_i: stall_o=4'b1111, flush_o=0, redirect suppressed. The jump stays in the stalled ex stage and is taken later.
  - MC_WAIT and not leaving it: stall_o=4'b0111 and flush_o[2]=1 (bubble into lsu). Load-use and jump are ignored.
  - RUN and ex_mc_start_i & !ex_mc_done_i: same as MC_WAIT, applied in the start cycle.
  - ex_jump_i: pc_redirect_o=1, flush_o=3'b011, stall_o=0. Jump beats load-use because the load-use instruction is younger and gets flushed.
  - id_load_use_i: stall_o=4'b0011, flush_o=3'b010.
  - Otherwise: all zero.
- A start and done in the same cycle is a single-cycle op: no stall, state stays RUN.
- pc_redirect_addr_o always equals ex_jump_addr_i. It is meaningful only when pc_redirect_o=1.

## Timing
- stall_o, flush_o, pc_redirect_o and mc_busy_o are combinational from the registered state, the watchdog counter, rst and the inputs. They take effect at the next clk edge in the pipeline registers.
- Stall release after done is zero-latency: the cycle ex_mc_done_i=1 (and lsu not busy) has stall_o=0.
- Jump latency: redirect is asserted in the same cycle as ex_jump_i, and the new PC is fetched the next cycle.
- Reset values: state RUN, watchdog 0, mc_err_o 0, both perf counters 0, mc_busy_o 0.
- Reset mid-MC_WAIT returns to RUN in the next cycle. mdu is reset in parallel.

## Configuration
- PIPE_CTRL_PERF_EN defined: both perf counters are implemented.
  - perf_stall_cnt_o increments on cycles where !rst & stall_o[0].
  - perf_flush_cnt_o increments on cycles where pc_redirect_o=1.
  - Both saturate at 32'hffffffff.
- PIPE_CTRL_PERF_EN undefined: the ports remain and are tied to 0. No counter flops are present.

## Structure
- defines.v holds the following shared constants, reused by the pipeline register modules:
  - stage index defines STALL_PC, STALL_IFID, STALL_IDEX, STALL_EXLSU;
  - FLUSH_* indices;
  - the state encoding PIPE_ST_RUN, PIPE_ST_MCWAIT;
  - the STALL_BUS / FLUSH_BUS widths.
- One sub-module, perf_cnt: a 32-bit saturating counter with synchronous clear and an increment enable, instantiated twice under PIPE_CTRL_PERF_EN.

## Test plan
- Load-use alone: id_load_use_i=1 for 1 cycle. Expect stall_o=4'b0011, flush_o=3'b010, then all zero next cycle.
- Jump plus load-use in the same cycle, ex_jump_addr_i=32'h0000_0100. Expect pc_redirect_o=1, pc_redirect_addr_o=32'h100, flush_o=3'b011, stall_o=0.
- Multi-cycle op: start held, done after 5 cycles.
  - Expect mc_busy_o=1 for cycles 2-5 and stall_o=4'b0111 with flush_o[2]=1 in cycles 1-5.
  - Expect stall_o=0 in the done cycle.
- lsu_busy_i=1 for 3 cycles with ex_jump_i=1 held. Expect stall_o=4'b1111 and no redirect for 3 cycles, then the redirect in cycle 4.
- Watchdog with MC_MAX_CYCLES=8 and done never asserted. Expect mc_err_o=1 after 8 MC_WAIT cycles, state RUN, and mc_err_o held until rst.
- PERF_EN: 10 load-use cycles plus 2 jumps. Expect perf_stall_cnt_o=10 and perf_flush_cnt_o=2. Preset near saturation and verify the counters hold at 32'hffffffff.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: constants shared by the pipeline control unit and the
// pipeline register modules. It holds the stall/flush bus widths, the bit index
// of each stage within those buses, and the control FSM state encoding.
package pipe_ctrl_pkg;

  localparam int STALL_BUS = 4;
  localparam int FLUSH_BUS = 3;

  // Bit positions in stall_o
  localparam int STALL_PC    = 0;
  localparam int STALL_IFID  = 1;
  localparam int STALL_IDEX  = 2;
  localparam int STALL_EXLSU = 3;

  // Bit positions in flush_o
  localparam int FLUSH_IFID  = 0;
  localparam int FLUSH_IDEX  = 1;
  localparam int FLUSH_EXLSU = 2;

  typedef enum logic {
    PIPE_ST_RUN    = 1'b0,
    PIPE_ST_MCWAIT = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// pipe_ctrl_perf_cnt: 32-bit saturating event counter.
// Ports:
//   clk    - clock
//   clr_i  - synchronous clear (highest priority)
//   inc_i  - count one event this cycle
//   cnt_o  - current count, holds at 32'hffffffff once reached
module pipe_ctrl_perf_cnt (
  input  logic        clk,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != 32'hffff_ffff)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the in-order RISC-V core.
// It merges hazard/redirect requests from idu, exu and lsu into per-stage
// stall and flush controls plus a PC redirect. It also sequences multi-cycle
// exu operations through a RUN/MC_WAIT state machine that has a watchdog.
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the two saturating
// performance counters. Without it, the perf ports are tied to zero.
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   id_load_use_i        - load-use hazard detected in id
//   ex_jump_i            - taken branch/jump in ex
//   ex_jump_addr_i       - redirect target
//   ex_mc_start_i        - multi-cycle op sitting in ex
//   ex_mc_done_i         - mdu result valid (level)
//   lsu_busy_i           - lsu access not complete
//   stall_o[3:0]         - hold pc, if/id, id/ex, ex/lsu
//   flush_o[2:0]         - bubble into if/id, id/ex, ex/lsu
//   pc_redirect_o        - load ex_jump_addr_i into the PC
//   pc_redirect_addr_o   - redirect target (pass-through)
//   mc_busy_o            - FSM is in MC_WAIT
//   mc_err_o             - sticky watchdog error
//   perf_stall_cnt_o     - cycles with stall_o[0]=1 outside reset
//   perf_flush_cnt_o     - accepted redirects
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_MAX_CYCLES = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_load_use_i,
  input  logic                 ex_jump_i,
  input  logic [31:0]          ex_jump_addr_i,
  input  logic                 ex_mc_start_i,
  input  logic                 ex_mc_done_i,
  input  logic                 lsu_busy_i,
  output logic [STALL_BUS-1:0] stall_o,
  output logic [FLUSH_BUS-1:0] flush_o,
  output logic                 pc_redirect_o,
  output logic [31:0]          pc_redirect_addr_o,
  output logic                 mc_busy_o,
  output logic                 mc_err_o,
  output logic [31:0]          perf_stall_cnt_o,
  output logic [31:0]          perf_flush_cnt_o
);

  // The counter value seen during the last allowed MC_WAIT cycle
  localparam logic [7:0] WD_LAST = 8'(MC_MAX_CYCLES - 1);

  pipe_state_e state_q, state_d;
  logic [7:0]  wd_q, wd_d;
  logic        mc_err_q, mc_err_d;

  logic in_wait;
  logic mc_pending;
  logic wd_hit;
  logic wait_done;
  logic wd_expire;
  logic leaving;

  logic [STALL_BUS-1:0] stall_d;
  logic [FLUSH_BUS-1:0] flush_d;
  logic                 redirect_d;

  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    mc_err_d   = mc_err_q;
    stall_d    = '0;
    flush_d    = '0;
    redirect_d = 1'b0;

    in_wait    = (state_q == PIPE_ST_MCWAIT);
    mc_pending = ex_mc_start_i & ~ex_mc_done_i;
    wd_hit     = (wd_q == WD_LAST);
    wait_done  = in_wait & ex_mc_done_i & ~lsu_busy_i;
    // The watchdog waits while lsu is busy, because lsu holds the whole
    // pipe and the drop bubble could not be issued. A done that arrives in
    // the limit cycle wins, so a finished op is never discarded.
    wd_expire  = in_wait & wd_hit & ~lsu_busy_i & ~ex_mc_done_i;
    leaving    = wait_done | wd_expire;

    // Next state
    if (in_wait) begin
      if (leaving) begin
        state_d = PIPE_ST_RUN;
      end else if (!wd_hit) begin
        wd_d = wd_q + 8'd1;
      end
    end else if (mc_pending && !lsu_busy_i && !ex_jump_i) begin
      state_d = PIPE_ST_MCWAIT;
      wd_d    = '0;
    end

    if (wd_expire) begin
      mc_err_d = 1'b1;
    end

    // Outputs, highest priority first
    if (rst || lsu_busy_i) begin
      stall_d[STALL_PC]    = 1'b1;
      stall_d[STALL_IFID]  = 1'b1;
      stall_d[STALL_IDEX]  = 1'b1;
      stall_d[STALL_EXLSU] = 1'b1;
    end else if ((in_wait && !leaving) || (!in_wait && mc_pending)) begin
      // Freeze the front of the pipe and feed bubbles into lsu while the
      // multi-cycle op occupies ex.
      stall_d[STALL_PC]    = 1'b1;
      stall_d[STALL_IFID]  = 1'b1;
      stall_d[STALL_IDEX]  = 1'b1;
      flush_d[FLUSH_EXLSU] = 1'b1;
    end else begin
      if (ex_jump_i) begin
        // The load-use consumer is younger than the jump and gets flushed.
        redirect_d          = 1'b1;
        flush_d[FLUSH_IFID] = 1'b1;
        flush_d[FLUSH_IDEX] = 1'b1;
      end else if (id_load_use_i) begin
        stall_d[STALL_PC]   = 1'b1;
        stall_d[STALL_IFID] = 1'b1;
        flush_d[FLUSH_IDEX] = 1'b1;
      end
      // The hung op moves out of ex this cycle, so it must not reach lsu.
      if (wd_expire) begin
        flush_d[FLUSH_EXLSU] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PIPE_ST_RUN;
      wd_q     <= '0;
      mc_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wd_q     <= wd_d;
      mc_err_q <= mc_err_d;
    end
  end

  assign stall_o            = stall_d;
  assign flush_o            = flush_d;
  assign pc_redirect_o      = redirect_d;
  assign pc_redirect_addr_o = ex_jump_addr_i;
  assign mc_busy_o          = in_wait;
  assign mc_err_o           = mc_err_q;

`ifdef PIPE_CTRL_PERF_EN
  // Index 0 counts stall cycles, index 1 counts redirects.
  logic [1:0]  perf_inc;
  logic [31:0] perf_cnt [2];

  assign perf_inc[0] = ~rst & stall_d[STALL_PC];
  assign perf_inc[1] = redirect_d;

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    pipe_ctrl_perf_cnt u_cnt (
      .clk   (clk),
      .clr_i (rst),
      .inc_i (perf_inc[gi]),
      .cnt_o (perf_cnt[gi])
    );
  end

  assign perf_stall_cnt_o = perf_cnt[0];
  assign perf_flush_cnt_o = perf_cnt[1];
`else
  assign perf_stall_cnt_o = '0;
  assign perf_flush_cnt_o = '0;
`endif

endmodule
